// File: rtl/ps2_event_buffer.sv
// PS/2 receive-side event parser with FWFT event FIFO and raw-byte history,
// plus the host-to-device command handshake (ACK wait, timeout, resend).
module ps2_event_buffer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HIST_BYTES  = 2,
  parameter int ACK_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          resetn,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [8*HIST_BYTES-1:0]       history,
  input  logic [7:0]                    cmd_byte,
  input  logic                          cmd_req,
  output logic                          cmd_busy,
  output logic                          cmd_done,
  output logic                          cmd_ok,
  output logic [7:0]                    the_command,
  output logic                          send_command,
  input  logic                          command_was_sent,
  input  logic                          error_communication_timed_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = 8 * HIST_BYTES;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {P_IDLE, P_E0, P_F0, P_E0F0} pstate_e;
  typedef enum logic [2:0] {C_IDLE, C_SEND, C_GAP, C_WAIT, C_END} cstate_e;

  pstate_e         pstate_q, pstate_d;
  logic            push_s;
  logic [9:0]      push_ev_s;
  logic            is_ext_s, is_brk_s;

  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [HW-1:0]   hist_q, hist_d;
  logic            pop_s, full_s, wr_en_s, drop_s;
  logic [9:0]      head_s;

  cstate_e         cstate_q;
  logic [RW-1:0]   retries_q;
  logic [TW-1:0]   timer_q;
  logic [7:0]      the_command_q;
  logic            send_q, busy_q, done_q, ok_q;
  logic            rx_ack_s, rx_resend_s, retry_ok_s, timeout_s;

  // Parser next state: prefixes set flags, FA/FE pass through untouched.
  always_comb begin
    pstate_d  = pstate_q;
    push_s    = 1'b0;
    is_ext_s  = (pstate_q == P_E0) || (pstate_q == P_E0F0);
    is_brk_s  = (pstate_q == P_F0) || (pstate_q == P_E0F0);
    push_ev_s = {is_ext_s, is_brk_s, rx_data};
    if (rx_valid) begin
      case (rx_data)
        8'hFA, 8'hFE: pstate_d = pstate_q;
        8'hE0: begin
          case (pstate_q)
            P_IDLE:         pstate_d = P_E0;
            P_E0, P_E0F0:   pstate_d = pstate_q;
            default: begin
              push_s   = 1'b1;
              pstate_d = P_IDLE;
            end
          endcase
        end
        8'hF0: begin
          case (pstate_q)
            P_IDLE:  pstate_d = P_F0;
            P_E0:    pstate_d = P_E0F0;
            default: pstate_d = pstate_q;
          endcase
        end
        default: begin
          push_s   = 1'b1;
          pstate_d = P_IDLE;
        end
      endcase
    end else begin
      pstate_d = pstate_q;
    end
  end

  // FIFO bookkeeping; a pop frees the slot so a push is taken even when full.
  always_comb begin
    pop_s      = ev_ready && (count_q != '0);
    full_s     = (count_q == CW'(FIFO_DEPTH));
    wr_en_s    = push_s && (!full_s || pop_s);
    drop_s     = push_s && full_s && !pop_s;
    wr_ptr_d   = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    hist_d = hist_q;
    if (rx_valid) begin
      hist_d      = hist_q << 8;
      hist_d[7:0] = rx_data;
    end else begin
      hist_d = hist_q;
    end
  end

  // Parser, FIFO and history registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pstate_q   <= P_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hist_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pstate_q   <= pstate_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hist_q     <= hist_d;
      if (wr_en_s) mem_q[wr_ptr_q] <= push_ev_s;
    end
  end

  // Reply decode for the command FSM.
  always_comb begin
    rx_ack_s    = rx_valid && (rx_data == 8'hFA);
    rx_resend_s = rx_valid && (rx_data == 8'hFE);
    retry_ok_s  = (retries_q < RW'(MAX_RETRY));
    timeout_s   = (timer_q == TW'(ACK_TIMEOUT - 1));
  end

  // Command handshake FSM; every output is registered alongside the state.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cstate_q      <= C_IDLE;
      retries_q     <= '0;
      timer_q       <= '0;
      the_command_q <= 8'h00;
      send_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ok_q          <= 1'b0;
    end else begin
      case (cstate_q)
        C_IDLE: begin
          if (cmd_req) begin
            the_command_q <= cmd_byte;
            retries_q     <= '0;
            send_q        <= 1'b1;
            busy_q        <= 1'b1;
            cstate_q      <= C_SEND;
          end
        end
        C_SEND: begin
          if (command_was_sent) begin
            send_q   <= 1'b0;
            timer_q  <= '0;
            cstate_q <= C_WAIT;
          end else if (error_communication_timed_out) begin
            send_q <= 1'b0;
            if (retry_ok_s) begin
              retries_q <= retries_q + RW'(1);
              cstate_q  <= C_GAP;
            end else begin
              done_q   <= 1'b1;
              ok_q     <= 1'b0;
              cstate_q <= C_END;
            end
          end
        end
        C_GAP: begin
          send_q   <= 1'b1;
          cstate_q <= C_SEND;
        end
        C_WAIT: begin
          if (rx_ack_s) begin
            done_q   <= 1'b1;
            ok_q     <= 1'b1;
            cstate_q <= C_END;
          end else if (rx_resend_s || timeout_s) begin
            if (retry_ok_s) begin
              retries_q <= retries_q + RW'(1);
              cstate_q  <= C_GAP;
            end else begin
              done_q   <= 1'b1;
              ok_q     <= 1'b0;
              cstate_q <= C_END;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        C_END: begin
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          cstate_q <= C_IDLE;
        end
        default: begin
          send_q   <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          cstate_q <= C_IDLE;
        end
      endcase
    end
  end

  assign head_s       = mem_q[rd_ptr_q];
  assign ev_code      = head_s[7:0];
  assign ev_break     = head_s[8];
  assign ev_ext       = head_s[9];
  assign ev_valid     = (count_q != '0);
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign history      = hist_q;
  assign cmd_busy     = busy_q;
  assign cmd_done     = done_q;
  assign cmd_ok       = ok_q;
  assign the_command  = the_command_q;
  assign send_command = send_q;

endmodule

// File: tb/tb_ps2_event_buffer.sv
// Directed bench for ps2_event_buffer: parser/FIFO vector table plus
// hand-written overflow, command handshake and mid-command reset sequences.
module tb_ps2_event_buffer;

  localparam int DEPTH = 8;
  localparam int HB    = 2;
  localparam int TO    = 200;
  localparam int MR    = 2;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  ev_code;
  logic        ev_ext, ev_break, ev_valid;
  logic        ev_ready = 1'b0;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic [15:0] history;
  logic [7:0]  cmd_byte = 8'h00;
  logic        cmd_req = 1'b0;
  logic        cmd_busy, cmd_done, cmd_ok;
  logic [7:0]  the_command;
  logic        send_command;
  logic        command_was_sent = 1'b0;
  logic        error_communication_timed_out = 1'b0;

  ps2_event_buffer #(
    .FIFO_DEPTH(DEPTH), .HIST_BYTES(HB), .ACK_TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .fifo_count(fifo_count), .overflow(overflow),
    .overflow_clr(overflow_clr), .history(history), .cmd_byte(cmd_byte),
    .cmd_req(cmd_req), .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_ok(cmd_ok),
    .the_command(the_command), .send_command(send_command),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int   errors = 0;
  int   checks = 0;
  int   rises  = 0;
  logic send_prev = 1'b0;

  always @(negedge CLOCK_50) begin
    if (send_command && !send_prev) rises++;
    send_prev = send_command;
  end

  typedef struct {
    logic       rxv;
    logic [7:0] rxd;
    logic       pop;
    logic       ev;
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [3:0] cnt;
    logic [15:0] hist;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic req(input logic [7:0] b);
    cmd_byte = b;
    cmd_req  = 1'b1;
    tick();
    cmd_req  = 1'b0;
  endtask

  task automatic was_sent();
    command_was_sent = 1'b1;
    tick();
    command_was_sent = 1'b0;
  endtask

  task automatic wait_send(input string name, input int budget);
    int n = 0;
    while (send_command !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, send_command}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_codes [8];
    int r0;

    //          rxv   rxd     pop   ev    ext   brk   code    cnt    hist
    vecs[0]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 4'd1, 16'h001C};
    vecs[1]  = '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 4'd1, 16'h1CF0};
    vecs[2]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 4'd2, 16'hF01C};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C, 4'd1, 16'hF01C};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 16'hF01C};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 16'hF01C};
    vecs[6]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 16'h1CE0};
    vecs[7]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 16'hE0F0};
    vecs[8]  = '{1'b1, 8'h75, 1'b0, 1'b1, 1'b1, 1'b1, 8'h75, 4'd1, 16'hF075};
    vecs[9]  = '{1'b1, 8'hE0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h75, 4'd1, 16'h75E0};
    vecs[10] = '{1'b1, 8'hE0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h75, 4'd1, 16'hE0E0};
    vecs[11] = '{1'b1, 8'h6B, 1'b0, 1'b1, 1'b1, 1'b1, 8'h75, 4'd2, 16'hE06B};
    vecs[12] = '{1'b1, 8'hFA, 1'b1, 1'b1, 1'b1, 1'b0, 8'h6B, 4'd1, 16'h6BFA};
    vecs[13] = '{1'b1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 8'h6B, 4'd1, 16'hFAFE};
    vecs[14] = '{1'b1, 8'hE1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h6B, 4'd2, 16'hFEE1};
    vecs[15] = '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h6B, 4'd2, 16'hE1F0};
    vecs[16] = '{1'b1, 8'hFA, 1'b0, 1'b1, 1'b1, 1'b0, 8'h6B, 4'd2, 16'hF0FA};
    vecs[17] = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 8'hE1, 4'd2, 16'hFA12};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 4'd1, 16'hFA12};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 16'hFA12};
    vecs[20] = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 16'h12F0};
    vecs[21] = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 16'hF0F0};
    vecs[22] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 4'd1, 16'hF05A};
    vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 16'hF05A};

    exp_codes = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};

    // Reset state.
    ticks(2);
    chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    chk("rst_count", {28'd0, fifo_count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_history", {16'd0, history}, 32'd0);
    chk("rst_send", {31'd0, send_command}, 32'd0);
    chk("rst_the_command", {24'd0, the_command}, 32'd0);
    chk("rst_busy", {31'd0, cmd_busy}, 32'd0);
    chk("rst_done", {31'd0, cmd_done}, 32'd0);
    chk("rst_ok", {31'd0, cmd_ok}, 32'd0);
    resetn = 1'b1;
    tick();

    // Parser / FIFO vector table.
    for (int i = 0; i < 24; i++) begin
      rx_data  = vecs[i].rxd;
      rx_valid = vecs[i].rxv;
      ev_ready = vecs[i].pop;
      tick();
      rx_valid = 1'b0;
      ev_ready = 1'b0;
      chk($sformatf("vec%0d_valid", i), {31'd0, ev_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_count", i), {28'd0, fifo_count}, {28'd0, vecs[i].cnt});
      chk($sformatf("vec%0d_hist", i), {16'd0, history}, {16'd0, vecs[i].hist});
      if (vecs[i].ev)
        chk($sformatf("vec%0d_head", i), {22'd0, ev_ext, ev_break, ev_code},
            {22'd0, vecs[i].ext, vecs[i].brk, vecs[i].code});
    end

    // Overflow: nine makes into an 8-deep FIFO.
    for (int i = 1; i <= 9; i++) rx(8'(i));
    chk("ovf_count", {28'd0, fifo_count}, 32'd8);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_head", {24'd0, ev_code}, 32'h01);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);
    overflow_clr = 1'b1;
    rx(8'h0B);
    overflow_clr = 1'b0;
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    chk("ovf_drop_count", {28'd0, fifo_count}, 32'd8);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    ev_ready = 1'b1;
    rx(8'h0A);
    ev_ready = 1'b0;
    chk("full_pushpop_count", {28'd0, fifo_count}, 32'd8);
    chk("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), {24'd0, ev_code}, {24'd0, exp_codes[i]});
      pop();
    end
    chk("drain_empty", {31'd0, ev_valid}, 32'd0);

    // Command A: ED, ACK after 100 cycles.
    req(8'hED);
    chk("a_send", {31'd0, send_command}, 32'd1);
    chk("a_busy", {31'd0, cmd_busy}, 32'd1);
    chk("a_cmd", {24'd0, the_command}, 32'hED);
    rx(8'hFA);
    chk("a_fa_in_send", {30'd0, send_command, cmd_done}, 32'd2);
    ticks(3);
    was_sent();
    chk("a_send_drop", {31'd0, send_command}, 32'd0);
    req(8'hAA);
    chk("a_req_ignored", {24'd0, the_command}, 32'hED);
    ticks(98);
    chk("a_no_done_yet", {31'd0, cmd_done}, 32'd0);
    rx(8'hFA);
    chk("a_done", {31'd0, cmd_done}, 32'd1);
    chk("a_ok", {31'd0, cmd_ok}, 32'd1);
    chk("a_fa_not_queued", {28'd0, fifo_count}, 32'd0);
    tick();
    chk("a_done_pulse", {30'd0, cmd_done, cmd_busy}, 32'd0);

    // Command C: controller error, then two ACK timeouts -> fail.
    r0 = rises;
    req(8'hF4);
    error_communication_timed_out = 1'b1;
    tick();
    error_communication_timed_out = 1'b0;
    chk("c_gap1", {31'd0, send_command}, 32'd0);
    wait_send("c_resend1", 4);
    was_sent();
    wait_send("c_resend2", TO + 10);
    was_sent();
    ticks(TO - 1);
    chk("c_timeout_edge", {31'd0, cmd_done}, 32'd0);
    tick();
    chk("c_done", {31'd0, cmd_done}, 32'd1);
    chk("c_ok", {31'd0, cmd_ok}, 32'd0);
    chk("c_attempts", rises - r0, 32'd3);
    tick();

    // Command B: FE then ACK on the resend.
    r0 = rises;
    req(8'hF3);
    was_sent();
    ticks(5);
    rx(8'hFE);
    chk("b_gap", {30'd0, send_command, cmd_busy}, 32'd1);
    tick();
    chk("b_resend", {31'd0, send_command}, 32'd1);
    was_sent();
    rx(8'hFA);
    chk("b_done_ok", {30'd0, cmd_done, cmd_ok}, 32'd3);
    chk("b_attempts", rises - r0, 32'd2);
    tick();

    // Reset while waiting for ACK with three queued events.
    rx(8'h1C);
    rx(8'h32);
    rx(8'h21);
    chk("d_count", {28'd0, fifo_count}, 32'd3);
    req(8'hF2);
    was_sent();
    #2 resetn = 1'b0;
    #1;
    chk("d_rst_fifo", {27'd0, fifo_count, ev_valid}, 32'd0);
    chk("d_rst_hist", {15'd0, history, overflow}, 32'd0);
    chk("d_rst_cmd", {20'd0, the_command, send_command, cmd_busy, cmd_done, cmd_ok}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    req(8'hFF);
    chk("d_new_req", {22'd0, the_command, send_command, cmd_busy}, {22'd0, 8'hFF, 2'b11});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
